alu_op_decoder: RTL and testbench
=================================

ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 SHALL have a single clock and a reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream holds a valid instruction-field set.
REQ-005 in_ready  output  1  decoder can accept this cycle; registered output, no combinational path from out_ready.
REQ-006 opcode  input  7  instruction bits [6:0].
REQ-007 funct3  input  3  instruction bits [14:12].
REQ-008 funct7_5  input  1  instruction bit 30.
REQ-009 out_valid  output  1  alu_op, alu_src_imm and illegal are valid.
REQ-010 out_ready  input  1  downstream ALU stage accepts this cycle.
REQ-011 alu_op  output  4  ALU operation code.
REQ-012 alu_src_imm  output  1  1 = operand B is the immediate, 0 = rs2.
REQ-013 illegal  output  1  entry is an unsupported opcode or funct combination.

Function
REQ-014 Input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
REQ-015 Entry storage: main register (drives outputs) plus one skid register; capacity 2; strict FIFO order.
REQ-016 Latency: an accepted entry SHALL appear on outputs the next cycle when main is empty or is transferring out the same cycle.
REQ-017 in_ready SHALL be 1 iff the skid register is empty.
REQ-018 Accept while main is full and not transferring out: entry goes to skid, in_ready falls next cycle.
REQ-019 Main transferring out with skid full: skid moves to main; a simultaneous accept is impossible because in_ready=0.
REQ-020 Simultaneous accept and transfer-out with skid empty: new entry replaces main, out_valid stays 1.
REQ-021 Outputs SHALL hold stable while out_valid&&!out_ready.
REQ-022 Codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, XOR 1100, SLL 1101, SRL 1110, SRA 1000.
REQ-023 opcode 0110011 (R), alu_src_imm=0: funct3 000 gives ADD when funct7_5=0 and SUB when 1; 111 AND; 110 OR; 010 SLT; 100 XOR; 001 SLL; 101 gives SRL when funct7_5=0 and SRA when 1.
REQ-024 opcode 0010011 (I), alu_src_imm=1: same table as REQ-023, except funct3 000 is always ADD.
REQ-025 opcode 0000011 (load) and 0100011 (store): ADD, alu_src_imm=1.
REQ-026 opcode 1100011 (branch): SUB, alu_src_imm=0.
REQ-027 The following SHALL be treated as illegal, with alu_op=0000, alu_src_imm=0 and illegal=1: any other opcode, and funct3 011 (SLTU) under R or I.
REQ-028 The decoder SHALL ignore input fields when in_valid=0.

Reset
REQ-029 When reset is asserted: out_valid=0, in_ready=1, both registers empty, and alu_op=0000, alu_src_imm=0, illegal=0.
REQ-030 Reset mid-operation SHALL discard stored entries; no output transfer SHALL occur in the reset cycle.
REQ-031 The first accept SHALL be possible in the cycle after reset deasserts.

Configuration
REQ-032 The macro ALU_DEC_ILLEGAL_DROP_EN selects the illegal-entry behaviour.
REQ-033 With ALU_DEC_ILLEGAL_DROP_EN undefined: illegal entries are enqueued and presented with illegal=1 (REQ-027).
REQ-034 With ALU_DEC_ILLEGAL_DROP_EN defined: illegal entries are accepted but never enqueued; illegal pulses 1 for exactly one cycle, the cycle after acceptance, independent of out_valid; illegal is never 1 on an enqueued entry.

Verification
REQ-035 Reset, then in_valid=1, opcode=0110011, funct3=000, funct7_5=1, out_ready=1 -> next cycle out_valid=1, alu_op=0110, alu_src_imm=0.
REQ-036 With out_ready=0, accept ADDI (0010011/000), then ORI (0010011/110) -> in_ready=0 after the 2nd accept; raising out_ready -> outputs 0010 then 0001 on consecutive cycles, both with alu_src_imm=1.
REQ-037 Back-to-back R-type SRL then SRA with out_ready=1 every cycle -> alu_op=1110 then 1101-free stream 1000, one entry per cycle, in_ready held 1.
REQ-038 opcode=1111111 -> macro undefined: out_valid=1, illegal=1, alu_op=0000; macro defined: out_valid stays 0 and illegal pulses for one cycle.
REQ-039 Two entries stored, reset asserted for one cycle -> next cycle out_valid=0, in_ready=1, and no stale entry appears afterwards.
REQ-040 Randomized out_ready stall pattern over 1000 entries -> output sequence equals the reference decode of the input sequence, with no loss or duplication.

Source files
------------

// File: rtl/alu_op_decoder.sv
// ALU operation decoder with a two-entry main/skid output buffer.
// Define ALU_DEC_ILLEGAL_DROP_EN to drop illegal entries and pulse illegal instead.
module alu_op_decoder (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] alu_op,
   output logic       alu_src_imm,
   output logic       illegal
);

   typedef struct packed {
      logic [3:0] op;
      logic       imm;
      logic       ill;
   } ent_t;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_XOR = 4'b1100;
   localparam logic [3:0] OP_SLL = 4'b1101;
   localparam logic [3:0] OP_SRL = 4'b1110;
   localparam logic [3:0] OP_SRA = 4'b1000;

   logic is_r, is_i, is_mem, is_br;
   logic [3:0] alu_f;
   ent_t dec, main_q, skid_q;
   logic main_v, skid_v;
   logic acc, pop, enq;

   assign is_r   = opcode == 7'b0110011;
   assign is_i   = opcode == 7'b0010011;
   assign is_mem = (opcode == 7'b0000011) || (opcode == 7'b0100011);
   assign is_br  = opcode == 7'b1100011;

   always_comb begin
      alu_f = OP_ADD;
      case (funct3)
         3'b000:  alu_f = (is_r && funct7_5) ? OP_SUB : OP_ADD;
         3'b001:  alu_f = OP_SLL;
         3'b010:  alu_f = OP_SLT;
         3'b100:  alu_f = OP_XOR;
         3'b101:  alu_f = funct7_5 ? OP_SRA : OP_SRL;
         3'b110:  alu_f = OP_OR;
         3'b111:  alu_f = OP_AND;
         default: alu_f = OP_ADD;
      endcase
   end

   always_comb begin
      dec = '0;
      unique case (1'b1)
         is_r: begin
            dec.op  = alu_f;
            dec.ill = funct3 == 3'b011;
         end
         is_i: begin
            dec.op  = alu_f;
            dec.imm = 1'b1;
            dec.ill = funct3 == 3'b011;
         end
         is_mem: begin
            dec.op  = OP_ADD;
            dec.imm = 1'b1;
         end
         is_br: dec.op = OP_SUB;
         default: dec.ill = 1'b1;
      endcase
      // illegal entries carry a canonical zero payload
      if (dec.ill) begin
         dec.op  = OP_AND;
         dec.imm = 1'b0;
      end
   end

   assign in_ready    = !skid_v;
   assign out_valid   = main_v;
   assign alu_op      = main_q.op;
   assign alu_src_imm = main_q.imm;
   assign acc         = in_valid && in_ready;
   assign pop         = main_v && out_ready;

`ifdef ALU_DEC_ILLEGAL_DROP_EN
   logic ill_pulse;

   assign enq     = acc && !dec.ill;
   assign illegal = ill_pulse;

   always_ff @(posedge clk) begin
      if (reset) ill_pulse <= 1'b0;
      else       ill_pulse <= acc && dec.ill;
   end
`else
   assign enq     = acc;
   assign illegal = main_q.ill;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else if (pop || !main_v) begin
         // skid full implies in_ready low, so no new entry competes here
         if (skid_v) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
         end else if (enq) begin
            main_q <= dec;
            main_v <= 1'b1;
         end else begin
            main_v <= 1'b0;
         end
      end else if (enq) begin
         skid_q <= dec;
         skid_v <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: directed cases plus a random stall run.
// Works with or without ALU_DEC_ILLEGAL_DROP_EN defined.
module tb_alu_op_decoder;

   typedef struct packed {
      logic [3:0] op;
      logic       imm;
      logic       ill;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       funct7_5 = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] alu_op;
   logic       alu_src_imm;
   logic       illegal;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   sent = 0;
   logic exp_pulse = 1'b0;

   always #5 clk = ~clk;

   alu_op_decoder dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .opcode(opcode),
      .funct3(funct3),
      .funct7_5(funct7_5),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .alu_op(alu_op),
      .alu_src_imm(alu_src_imm),
      .illegal(illegal)
   );

   function automatic exp_t ref_dec(logic [6:0] opc, logic [2:0] f3, logic f7);
      exp_t e;
      e = '0;
      if (opc == 7'h33 || opc == 7'h13) begin
         e.imm = (opc == 7'h13);
         case (f3)
            3'd0: e.op = (opc == 7'h33 && f7) ? 4'b0110 : 4'b0010;
            3'd1: e.op = 4'b1101;
            3'd2: e.op = 4'b0111;
            3'd3: e = '{op: 4'b0000, imm: 1'b0, ill: 1'b1};
            3'd4: e.op = 4'b1100;
            3'd5: e.op = f7 ? 4'b1000 : 4'b1110;
            3'd6: e.op = 4'b0001;
            default: e.op = 4'b0000;
         endcase
      end else if (opc == 7'h03 || opc == 7'h23) begin
         e.op  = 4'b0010;
         e.imm = 1'b1;
      end else if (opc == 7'h63) begin
         e.op = 4'b0110;
      end else begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(logic v, logic [6:0] opc, logic [2:0] f3,
                        logic f7, logic ordy);
      in_valid  = v;
      opcode    = opc;
      funct3    = f3;
      funct7_5  = f7;
      out_ready = ordy;
   endtask

   // sample mid-cycle, update the scoreboard, then advance one clock
   task automatic cycle();
      exp_t e, r;
      logic acc, pop;
      #1;
      if (reset) begin
         q.delete();
         exp_pulse = 1'b0;
      end else begin
         acc = in_valid && in_ready;
         pop = out_valid && out_ready;
         chk("in_ready", {7'd0, in_ready}, {7'd0, q.size() < 2});
         chk("out_valid", {7'd0, out_valid}, {7'd0, q.size() != 0});
         if (out_valid && q.size() != 0) begin
            e = q[0];
            chk("alu_op", {4'd0, alu_op}, {4'd0, e.op});
            chk("alu_src_imm", {7'd0, alu_src_imm}, {7'd0, e.imm});
`ifndef ALU_DEC_ILLEGAL_DROP_EN
            chk("illegal", {7'd0, illegal}, {7'd0, e.ill});
`endif
         end
`ifdef ALU_DEC_ILLEGAL_DROP_EN
         chk("illegal_pulse", {7'd0, illegal}, {7'd0, exp_pulse});
`endif
         if (pop && q.size() != 0) void'(q.pop_front());
         exp_pulse = 1'b0;
         if (acc) begin
            r = ref_dec(opcode, funct3, funct7_5);
            sent++;
`ifdef ALU_DEC_ILLEGAL_DROP_EN
            if (r.ill) exp_pulse = 1'b1;
            else q.push_back(r);
`else
            q.push_back(r);
`endif
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [6:0] opcs [7];
      opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7f, 7'h37};

      // reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
      chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
      chk("rst_alu_op", {4'd0, alu_op}, 8'd0);
      chk("rst_imm", {7'd0, alu_src_imm}, 8'd0);
      chk("rst_illegal", {7'd0, illegal}, 8'd0);
      @(negedge clk);
      reset = 1'b0;

      // SUB accepted right after reset, visible next cycle
      drive(1, 7'h33, 3'b000, 1, 1);
      cycle();
      drive(0, 7'h55, 3'b111, 1, 1);
      cycle();
      cycle();

      // two entries stored behind a stall, then drained
      drive(1, 7'h13, 3'b000, 1, 0);
      cycle();
      drive(1, 7'h13, 3'b110, 0, 0);
      cycle();
      drive(1, 7'h33, 3'b100, 0, 0);
      cycle();
      drive(0, 7'h00, 3'b000, 0, 1);
      cycle();
      cycle();
      cycle();

      // back-to-back SRL then SRA, then SLTU and unknown opcode
      drive(1, 7'h33, 3'b101, 0, 1);
      cycle();
      drive(1, 7'h33, 3'b101, 1, 1);
      cycle();
      drive(1, 7'h7f, 3'b000, 0, 1);
      cycle();
      drive(1, 7'h13, 3'b011, 0, 1);
      cycle();
      drive(1, 7'h63, 3'b001, 0, 1);
      cycle();
      drive(1, 7'h23, 3'b010, 0, 1);
      cycle();
      drive(0, 7'h00, 3'b000, 0, 1);
      cycle();
      cycle();
      cycle();

      // reset with two entries held
      drive(1, 7'h33, 3'b111, 0, 0);
      cycle();
      drive(1, 7'h13, 3'b010, 0, 0);
      cycle();
      drive(0, 7'h00, 3'b000, 0, 1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      #1;
      chk("post_rst_alu_op", {4'd0, alu_op}, 8'd0);
      chk("post_rst_illegal", {7'd0, illegal}, 8'd0);
      cycle();
      cycle();
      cycle();

      // random stall run over 1000 accepted entries
      sent = 0;
      for (int c = 0; c < 20000 && sent < 1000; c++) begin
         drive($urandom_range(3) != 0, opcs[$urandom_range(6)],
               3'($urandom), 1'($urandom), $urandom_range(2) != 0);
         if ($urandom_range(15) == 0) opcode = 7'($urandom);
         cycle();
      end
      chk("rand_budget", {7'd0, sent >= 1000}, 8'd1);
      drive(0, 7'h00, 3'b000, 0, 1);
      for (int c = 0; c < 10 && q.size() != 0; c++) cycle();
      cycle();
      chk("drain_empty", 8'(q.size()), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
